// File: rtl/uart_rx_frame.sv
//------------------------------------------------------------------------------
// Module   : uart_rx_frame
// Purpose  : UART receive engine. Deserialises an asynchronous framed line
//            (start, LSB-first data, optional parity, 1 or 2 stop bits) into
//            parallel words with per-word parity and framing status.
// Ports    : i_clk           - system clock, rising edge
//            i_rst_n         - asynchronous active-low reset
//            i_uart_rx       - serial line, idle high, asynchronous
//            o_user_rx_data  - received word, LSB = first data bit
//            o_user_rx_valid - one-cycle strobe per completed frame
//            o_parity_err    - parity mismatch for o_user_rx_data
//            o_frame_err     - a stop bit was sampled low for o_user_rx_data
//            o_rx_busy       - high whenever the receiver is not idle
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_frame #(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BUADRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_uart_rx,
  output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
  output logic                         o_user_rx_valid,
  output logic                         o_parity_err,
  output logic                         o_frame_err,
  output logic                         o_rx_busy
);

  // Bit period in system clocks (integer division).
  localparam int c_bit_period = P_SYSTEM_CLK / P_UART_BUADRATE;
  localparam int c_cnt_w      = (c_bit_period > 2) ? $clog2(c_bit_period) : 1;
  localparam int c_bit_w      = 4;

  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_bit_period - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_mid  = c_cnt_w'(c_bit_period / 2 - 1);
  localparam logic [c_bit_w-1:0] c_data_last = c_bit_w'(P_UART_DATA_WIDTH - 1);
  // Index of the final stop sample: 0 for one stop bit, 1 for two.
  localparam logic               c_stop_last = (P_UART_STOP_WIDTH == 2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                         r_state;
  state_t                         w_next_state;
  logic                           r_sync1;
  logic                           r_sync2;
  logic                           r_prev;
  logic [c_cnt_w-1:0]             r_cnt;
  logic [c_bit_w-1:0]             r_bit_idx;
  logic                           r_stop_idx;
  logic [P_UART_DATA_WIDTH-1:0]   r_shift;
  logic                           r_perr;
  logic                           r_ferr;
  logic                           w_fall;
  logic                           w_sample_en;
  logic                           w_frame_done;

  // Falling edge of the synchronised line.
  assign w_fall    = r_prev & ~r_sync2;
  assign o_rx_busy = (r_state != ST_IDLE);

  //--------------------------------------------------------------------------
  // Input synchroniser and previous-sample register (idle level is high).
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_uart_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state logic and sample strobe
  //--------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_sample_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_next_state = ST_START;
        end
      end
      ST_START: begin
        // Half-bit check: a line back high here was only a glitch.
        if (r_cnt == c_cnt_mid) begin
          w_sample_en  = 1'b1;
          w_next_state = r_sync2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_cnt == c_cnt_last) begin
          w_sample_en = 1'b1;
          if (r_bit_idx == c_data_last) begin
            w_next_state = (P_UART_CHECK != 0) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (r_cnt == c_cnt_last) begin
          w_sample_en  = 1'b1;
          w_next_state = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leaving mid-stop-bit lets an immediately following start edge
        // be seen from IDLE.
        if (r_cnt == c_cnt_last) begin
          w_sample_en = 1'b1;
          if (r_stop_idx == c_stop_last) begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    w_frame_done = (r_state == ST_STOP) && w_sample_en && (w_next_state == ST_IDLE);
  end

  //--------------------------------------------------------------------------
  // Bit timing, shift register and status accumulation
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) || (r_state != w_next_state) || (r_cnt == c_cnt_last)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == ST_START) begin
        r_bit_idx <= '0;
        r_perr    <= 1'b0;
        r_ferr    <= 1'b0;
      end

      if (r_state != ST_STOP) begin
        r_stop_idx <= 1'b0;
      end else if (w_sample_en) begin
        r_stop_idx <= 1'b1;
      end

      if ((r_state == ST_DATA) && w_sample_en) begin
        // Shifting in from the top leaves the first bit in the LSB once
        // all data bits have arrived.
        r_shift   <= {r_sync2, r_shift[P_UART_DATA_WIDTH-1:1]};
        r_bit_idx <= r_bit_idx + 1'b1;
      end

      if ((r_state == ST_PARITY) && w_sample_en) begin
        if (P_UART_CHECK == 1) begin
          r_perr <= ~(^r_shift ^ r_sync2);
        end else begin
          r_perr <= ^r_shift ^ r_sync2;
        end
      end

      if ((r_state == ST_STOP) && w_sample_en && !r_sync2) begin
        r_ferr <= 1'b1;
      end
    end
  end

  //--------------------------------------------------------------------------
  // User outputs: loaded together with the strobe, held until the next one.
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_user_rx_data  <= '0;
      o_user_rx_valid <= 1'b0;
      o_parity_err    <= 1'b0;
      o_frame_err     <= 1'b0;
    end else begin
      o_user_rx_valid <= w_frame_done;
      if (w_frame_done) begin
        o_user_rx_data <= r_shift;
        o_parity_err   <= (P_UART_CHECK != 0) && r_perr;
        // The final stop sample is folded in directly.
        o_frame_err    <= r_ferr | ~r_sync2;
      end
    end
  end

endmodule

`default_nettype wire
